// File: rtl/asm_loop_ctrl_pkg.sv
// Shared types and constants for the looping ASM controller.
package asm_loop_ctrl_pkg;

  localparam int unsigned ST_W      = 3;
  localparam int unsigned CNT_W_DEF = 4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DISP  = 3'd2,
    S_FAST  = 3'd3,
    S_RUN   = 3'd4,
    S_EXT   = 3'd5,
    S_DRAIN = 3'd6,
    S_DONE  = 3'd7
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder; purely combinational.
module onehot_dec #(
  parameter int unsigned W_IN = 3
) (
  input  logic [W_IN-1:0]      bin,
  output logic [(2**W_IN)-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[bin] = 1'b1;
  end

endmodule

// File: rtl/asm_loop_ctrl.sv
// Looping ASM controller: start/done handshake, latched branch modes and a
// saturating down-counter that sets the RUN length.
module asm_loop_ctrl #(
  parameter int unsigned CNT_W = asm_loop_ctrl_pkg::CNT_W_DEF,
  parameter int unsigned ST_W  = asm_loop_ctrl_pkg::ST_W
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode_f,
  input  logic                   mode_e,
  input  logic [CNT_W-1:0]       len,
  input  logic                   hold,
  output logic [ST_W-1:0]        state,
  output logic [(2**ST_W)-1:0]   dec_out,
  output logic [CNT_W-1:0]       cnt,
  output logic                   busy,
  output logic                   done
);

  import asm_loop_ctrl_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             f_q, f_d;
  logic             e_q, e_d;

  // State, counter and latched modes
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f_q     <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      e_q     <= e_d;
    end
  end

  // Next-state and datapath control; abort overrides everything but keeps data
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    e_d     = e_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) state_d = S_LOAD;
        S_LOAD: begin
          cnt_d   = len;
          f_d     = mode_f;
          e_d     = mode_e;
          state_d = S_DISP;
        end
        S_DISP: state_d = f_q ? S_FAST : S_RUN;
        S_FAST: state_d = S_DONE;
        S_RUN: begin
          if (!hold) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else             state_d = e_q ? S_EXT : S_DRAIN;
          end
        end
        S_EXT:   state_d = S_DONE;
        S_DRAIN: state_d = S_DONE;
        S_DONE:  state_d = start ? S_LOAD : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign state = state_q;
  assign cnt   = cnt_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);

  onehot_dec #(.W_IN(ST_W)) u_dec (
    .bin    (state_q),
    .onehot (dec_out)
  );

endmodule

// File: tb/tb_asm_loop_ctrl.sv
// Bench for asm_loop_ctrl: literal directed sequences plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_asm_loop_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ST_W  = 3;

  logic             clk;
  logic             rst_b;
  logic             start, abort, mode_f, mode_e, hold;
  logic [CNT_W-1:0] len;
  logic [ST_W-1:0]  state;
  logic [7:0]       dec_out;
  logic [CNT_W-1:0] cnt;
  logic             busy, done;

  int checks   = 0;
  int failures = 0;

  asm_loop_ctrl #(.CNT_W(CNT_W), .ST_W(ST_W)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .start   (start),
    .abort   (abort),
    .mode_f  (mode_f),
    .mode_e  (mode_e),
    .len     (len),
    .hold    (hold),
    .state   (state),
    .dec_out (dec_out),
    .cnt     (cnt),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  // Reference model: tracks phase and remaining un-held RUN cycles of the job
  int exp_state, exp_cnt, m_f, m_e, runs_left;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      exp_state <= 0;
      exp_cnt   <= 0;
      m_f       <= 0;
      m_e       <= 0;
      runs_left <= 0;
    end else if (abort) begin
      exp_state <= 0;
    end else begin
      case (exp_state)
        0: if (start) exp_state <= 1;
        1: begin
          exp_cnt   <= int'(len);
          m_f       <= int'(mode_f);
          m_e       <= int'(mode_e);
          runs_left <= int'(len) + 1;
          exp_state <= 2;
        end
        2: exp_state <= (m_f != 0) ? 3 : 4;
        3, 5, 6: exp_state <= 7;
        4: if (!hold) begin
          runs_left <= runs_left - 1;
          exp_cnt   <= (runs_left > 1) ? runs_left - 2 : 0;
          if (runs_left == 1) exp_state <= (m_e != 0) ? 5 : 6;
        end
        7: exp_state <= start ? 1 : 0;
        default: exp_state <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_b) begin
      check("m_state", int'(state), exp_state);
      check("m_cnt",   int'(cnt),   exp_cnt);
      check("m_dec",   int'(dec_out), 1 << exp_state);
      check("m_busy",  int'(busy),  (exp_state != 0) ? 1 : 0);
      check("m_done",  int'(done),  (exp_state == 7) ? 1 : 0);
    end
  end

  int seq_s[9];
  int seq_c[9];

  // Start one job and compare n observed cycles against the literal tables
  task automatic run_dir(input string nm, input logic [CNT_W-1:0] l,
                         input logic f, input logic e,
                         input int hf, input int hn, input int n);
    logic [7:0] d;
    @(negedge clk);
    len = l; mode_f = f; mode_e = e; start = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      start = 1'b0;
      d = 8'(1) << seq_s[j];
      check({nm, "_state"}, int'(state), seq_s[j]);
      check({nm, "_dec"}, int'(dec_out), int'(d));
      check({nm, "_done"}, int'(done), (seq_s[j] == 7) ? 1 : 0);
      if (seq_c[j] >= 0) check({nm, "_cnt"}, int'(cnt), seq_c[j]);
      hold = (j >= hf && j < hf + hn);
    end
    hold = 1'b0;
  endtask

  task automatic wait_state(input string nm, input int s, input int budget);
    int k;
    k = 0;
    while (int'(state) != s && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (int'(state) != s) check({nm, "_timeout"}, int'(state), s);
  endtask

  initial begin
    int runs;
    bit saw_idle;
    rst_b = 1'b0; start = 1'b0; abort = 1'b0; mode_f = 1'b0; mode_e = 1'b0;
    hold = 1'b0; len = '0;
    repeat (2) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_dec", int'(dec_out), 8'h01);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_state", int'(state), 0);
    check("idle_dec", int'(dec_out), 8'h01);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    check("idle_cnt", int'(cnt), 0);

    seq_s = '{1, 2, 4, 4, 4, 4, 6, 7, 0};
    seq_c = '{-1, 3, 3, 2, 1, 0, 0, 0, 0};
    run_dir("plain", 4'd3, 1'b0, 1'b0, 99, 0, 9);

    seq_s = '{1, 2, 3, 7, 0, 0, 0, 0, 0};
    seq_c = '{-1, 9, 9, 9, 9, 9, 9, 9, 9};
    run_dir("fast", 4'd9, 1'b1, 1'b0, 99, 0, 5);

    seq_s = '{1, 2, 4, 4, 4, 4, 5, 7, 0};
    seq_c = '{-1, 1, 1, 1, 1, 0, 0, 0, 0};
    run_dir("ext", 4'd1, 1'b0, 1'b1, 2, 2, 9);

    seq_s = '{1, 2, 4, 6, 7, 0, 0, 0, 0};
    seq_c = '{-1, 0, 0, 0, 0, 0, 0, 0, 0};
    run_dir("len0", 4'd0, 1'b0, 1'b0, 99, 0, 6);

    // Maximum length: 16 RUN cycles, counter saturates at zero
    @(negedge clk);
    len = 4'hF; mode_f = 1'b0; mode_e = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    runs = 0;
    for (int k = 0; k < 40 && int'(state) != 7; k++) begin
      @(negedge clk);
      if (int'(state) == 4) runs++;
    end
    check("lenF_runs", runs, 16);
    check("lenF_done_cnt", int'(cnt), 0);
    wait_state("lenF_idle", 0, 5);

    // start held through DONE: straight back into LOAD
    @(negedge clk);
    len = 4'd2; mode_f = 1'b1; start = 1'b1;
    saw_idle = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 20 && int'(state) != 7; k++) begin
      @(negedge clk);
      if (int'(state) == 0) saw_idle = 1'b1;
    end
    @(negedge clk);
    check("b2b_state", int'(state), 1);
    check("b2b_no_idle", int'(saw_idle), 0);
    start = 1'b0;
    wait_state("b2b_idle", 0, 20);

    // Abort in RUN with cnt=5
    @(negedge clk);
    len = 4'd9; mode_f = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 30 && !(int'(state) == 4 && int'(cnt) == 5); k++) @(negedge clk);
    check("abort_pre_cnt", int'(cnt), 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", int'(state), 0);
    check("abort_cnt", int'(cnt), 5);
    check("abort_done", int'(done), 0);

    // abort and start together in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", int'(state), 0);

    // Asynchronous reset in the middle of RUN
    len = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_dec", int'(dec_out), 8'h01);
    check("arst_cnt", int'(cnt), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    @(negedge clk);
    #2 rst_b = 1'b1;

    // Randomized traffic, checked by the model every cycle
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 3) == 0);
      abort  = ($urandom_range(0, 31) == 0);
      hold   = ($urandom_range(0, 2) == 0);
      len    = CNT_W'($urandom);
      mode_f = ($urandom_range(0, 3) == 0);
      mode_e = 1'($urandom);
    end
    start = 1'b0; abort = 1'b0; hold = 1'b0;
    repeat (25) @(negedge clk);
    check("final_idle", int'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
